// File: rtl/alu_bist_if.sv
// ALU datapath bus between the BIST sequencer and the ALU under test.
//   a, b        : operands, driven by the sequencer
//   ALUControl  : opcode, driven by the sequencer
//   result      : ALU result, combinational from a/b/ALUControl
//   zero        : ALU zero flag
// master = sequencer side, slave = ALU side.
interface alu_bist_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (output a, b, ALUControl, input result, zero);
  modport slave  (input a, b, ALUControl, output result, zero);
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 64-bit datapath ALU.
// Sweeps a fixed operand/opcode set onto the ALU, computes the golden result
// from the registered operands and counts vectors whose result or zero flag
// disagree.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a sweep (honoured only in IDLE or DONE)
//   alu         : ALU bus (a, b, ALUControl out; result, zero in)
//   busy        : sweep in progress
//   done        : sweep finished, held until next start or reset
//   fail        : sticky, any vector of the current sweep mismatched
//   error_count : mismatching vectors, saturating
module alu_bist #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 10,
  parameter int unsigned ERRW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  alu_bist_if.master      alu,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [ERRW-1:0] error_count
);

  localparam int unsigned   IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [2:0]    OP_LAST  = 3'd5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic             phase, phase_nxt, phase_step;
  logic [IW-1:0]    i_idx, i_nxt, i_step;
  logic [IW-1:0]    j_idx, j_nxt, j_step;
  logic [2:0]       op_idx, op_nxt, op_step;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [3:0]       ctl_q, ctl_nxt;
  logic             busy_nxt, done_nxt, fail_nxt;
  logic [ERRW-1:0]  err_nxt;
  logic [WIDTH-1:0] golden_c;
  logic             mismatch_c, last_c;

  function automatic logic [3:0] op_code(input logic [2:0] k);
    case (k)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0111;
      default: return 4'b1100;
    endcase
  endfunction

  // Phase 1 sweeps j downward: 0, -1, .. -(N-1), sign-extended.
  function automatic logic [WIDTH-1:0] operand_b(input logic ph, input logic [IW-1:0] j);
    logic [WIDTH-1:0] mag;
    mag = WIDTH'(j);
    return ph ? (~mag + WIDTH'(1)) : mag;
  endfunction

  assign alu.a          = a_q;
  assign alu.b          = b_q;
  assign alu.ALUControl = ctl_q;

  // Golden result from the operands currently on the bus.
  always_comb begin
    golden_c = '0;
    case (ctl_q)
      4'b0000: golden_c = a_q & b_q;
      4'b0001: golden_c = a_q | b_q;
      4'b0010: golden_c = a_q + b_q;
      4'b0110: golden_c = a_q - b_q;
      4'b0111: golden_c = b_q;
      4'b1100: golden_c = ~(a_q | b_q);
      default: golden_c = '0;
    endcase
  end

  assign mismatch_c = (alu.result != golden_c) || (alu.zero != (golden_c == '0));
  assign last_c     = phase && (i_idx == IDX_LAST) && (j_idx == IDX_LAST) && (op_idx == OP_LAST);

  // Odometer: opcode fastest, then j, then i, then phase.
  always_comb begin
    op_step    = (op_idx == OP_LAST) ? 3'd0 : op_idx + 3'd1;
    j_step     = j_idx;
    i_step     = i_idx;
    phase_step = phase;
    if (op_idx == OP_LAST) begin
      j_step = (j_idx == IDX_LAST) ? '0 : j_idx + IW'(1);
      if (j_idx == IDX_LAST) begin
        i_step = (i_idx == IDX_LAST) ? '0 : i_idx + IW'(1);
        if (i_idx == IDX_LAST) phase_step = ~phase;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    i_nxt     = i_idx;
    j_nxt     = j_idx;
    op_nxt    = op_idx;
    a_nxt     = a_q;
    b_nxt     = b_q;
    ctl_nxt   = ctl_q;
    busy_nxt  = busy;
    done_nxt  = done;
    fail_nxt  = fail;
    err_nxt   = error_count;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_DRIVE;
          phase_nxt = 1'b0;
          i_nxt     = '0;
          j_nxt     = '0;
          op_nxt    = 3'd0;
          a_nxt     = '0;
          b_nxt     = '0;
          ctl_nxt   = op_code(3'd0);
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          err_nxt   = '0;
        end
      end
      S_DRIVE: state_nxt = S_CHECK;
      S_CHECK: begin
        if (mismatch_c) begin
          fail_nxt = 1'b1;
          err_nxt  = (error_count == '1) ? error_count : error_count + ERRW'(1);
        end
        if (last_c) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = S_DRIVE;
          phase_nxt = phase_step;
          i_nxt     = i_step;
          j_nxt     = j_step;
          op_nxt    = op_step;
          a_nxt     = WIDTH'(i_step);
          b_nxt     = operand_b(phase_step, j_step);
          ctl_nxt   = op_code(op_step);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      i_idx       <= '0;
      j_idx       <= '0;
      op_idx      <= 3'd0;
      a_q         <= '0;
      b_q         <= '0;
      ctl_q       <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      i_idx       <= i_nxt;
      j_idx       <= j_nxt;
      op_idx      <= op_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      ctl_q       <= ctl_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      fail        <= fail_nxt;
      error_count <= err_nxt;
    end
  end

endmodule
